// File: rtl/nvdla_cacc_reg_pkg.sv
// Shared definitions for the CACC group control register block: state encoding,
// register offsets, error bit indices and status field placement.
package nvdla_cacc_reg_pkg;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    localparam logic [11:0] OFS_STATUS    = 12'h000;
    localparam logic [11:0] OFS_POINTER   = 12'h004;
    localparam logic [11:0] OFS_OP_ENABLE = 12'h008;
    localparam logic [11:0] OFS_ERR       = 12'h00C;

    localparam int ERR_LAUNCH = 0;
    localparam int ERR_PROTO  = 1;

    // Even groups fill the low half-word, odd groups the high half-word.
    function automatic int status_pos(input int g);
        return 16 * (g & 1) + 2 * (g >> 1);
    endfunction

endpackage

// File: rtl/nvdla_cacc_group_fsm.sv
// Per-group status tracker: IDLE -> PENDING on launch, -> RUNNING on start, -> IDLE on done.
// All qualifiers are judged against the state held at the start of the cycle.
module nvdla_cacc_group_fsm
    import nvdla_cacc_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       launch,
    input  logic       start,
    input  logic       done,
    output grp_state_e state,
    output logic       launch_err,
    output logic       proto_err
);

    grp_state_e state_q;
    grp_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= GRP_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        launch_err = 1'b0;
        proto_err  = 1'b0;
        if (launch) begin
            if (state_q == GRP_IDLE) state_d = GRP_PENDING;
            else                     launch_err = 1'b1;
        end
        if (start) begin
            if (state_q == GRP_PENDING) state_d = GRP_RUNNING;
            else                        proto_err = 1'b1;
        end
        if (done) begin
            if (state_q == GRP_RUNNING) state_d = GRP_IDLE;
            else                        proto_err = 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/nvdla_cacc_group_ctrl_reg.sv
// CSB-visible control for NUM_GROUPS CACC register groups: pointers, per-group status,
// error flags, combinational read mux and one-cycle done interrupt.
module nvdla_cacc_group_ctrl_reg
    import nvdla_cacc_reg_pkg::*;
#(
    parameter  int          NUM_GROUPS  = 2,
    localparam int          PTR_W       = $clog2(NUM_GROUPS),
    parameter  logic [11:0] BASE_OFFSET = 12'h000
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic [11:0]           reg_offset,
    input  logic [31:0]           reg_wr_data,
    input  logic                  reg_wr_en,
    output logic [31:0]           reg_rd_data,
    output logic [PTR_W-1:0]      producer,
    output logic [PTR_W-1:0]      consumer,
    output logic [NUM_GROUPS-1:0] op_en,
    input  logic                  op_start,
    input  logic                  op_done,
    output logic                  done_irq
);

    localparam logic [11:0] ADDR_STATUS    = BASE_OFFSET + OFS_STATUS;
    localparam logic [11:0] ADDR_POINTER   = BASE_OFFSET + OFS_POINTER;
    localparam logic [11:0] ADDR_OP_ENABLE = BASE_OFFSET + OFS_OP_ENABLE;
    localparam logic [11:0] ADDR_ERR       = BASE_OFFSET + OFS_ERR;

    grp_state_e            grp_state [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] grp_launch_err;
    logic [NUM_GROUPS-1:0] grp_proto_err;
    logic [1:0]            err;
    logic [1:0]            err_set;
    logic [1:0]            err_clr;
    logic                  launch_wr;
    logic                  start_ok;
    logic                  done_ok;
    logic                  unused_wr_bits;

    assign launch_wr = reg_wr_en && (reg_offset == ADDR_OP_ENABLE) && reg_wr_data[0];
    // Done wins a start/done collision; the dropped start is a protocol error.
    assign start_ok  = op_start && !op_done;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        nvdla_cacc_group_fsm u_fsm (
            .clk        (nvdla_core_clk),
            .rst        (nvdla_core_rst),
            .launch     (launch_wr && (producer == PTR_W'(g))),
            .start      (start_ok && (consumer == PTR_W'(g))),
            .done       (op_done && (consumer == PTR_W'(g))),
            .state      (grp_state[g]),
            .launch_err (grp_launch_err[g]),
            .proto_err  (grp_proto_err[g])
        );
        assign op_en[g] = (grp_state[g] != GRP_IDLE);
    end

    assign done_ok = op_done && (grp_state[consumer] == GRP_RUNNING);

    always_comb begin
        err_set             = '0;
        err_set[ERR_LAUNCH] = |grp_launch_err;
        err_set[ERR_PROTO]  = (|grp_proto_err) || (op_start && op_done);
        err_clr             = (reg_wr_en && reg_offset == ADDR_ERR) ? reg_wr_data[1:0] : 2'b00;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            producer <= '0;
            consumer <= '0;
            err      <= '0;
            done_irq <= 1'b0;
        end else begin
            if (reg_wr_en && reg_offset == ADDR_POINTER)
                producer <= reg_wr_data[PTR_W-1:0];
            if (done_ok)
                consumer <= consumer + PTR_W'(1);
            err      <= (err & ~err_clr) | err_set;
            done_irq <= done_ok;
        end
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_offset)
            ADDR_STATUS: begin
                for (int g = 0; g < NUM_GROUPS; g++)
                    reg_rd_data[status_pos(g) +: 2] = grp_state[g];
            end
            ADDR_POINTER: begin
                reg_rd_data[PTR_W-1:0]  = producer;
                reg_rd_data[16 +: PTR_W] = consumer;
            end
            ADDR_OP_ENABLE: reg_rd_data[0]   = op_en[producer];
            ADDR_ERR:       reg_rd_data[1:0] = err;
            default:        reg_rd_data      = '0;
        endcase
    end

    assign unused_wr_bits = ^reg_wr_data[31:2];

endmodule

// File: tb/tb_nvdla_cacc_group_ctrl_reg.sv
// Directed bench: a 2-group and a 4-group instance share clock and reset.
module tb_nvdla_cacc_group_ctrl_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] off  [2];
    logic [31:0] wdat [2];
    logic        wen  [2];
    logic        st   [2];
    logic        dn   [2];

    logic [31:0] rd2, rd4;
    logic        prod2, cons2, irq2, irq4;
    logic [1:0]  prod4, cons4, open2;
    logic [3:0]  open4;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    localparam logic [11:0] A_STAT = 12'h000;
    localparam logic [11:0] A_PTR  = 12'h004;
    localparam logic [11:0] A_OPEN = 12'h008;
    localparam logic [11:0] A_ERR  = 12'h00C;

    always #5 clk = ~clk;

    nvdla_cacc_group_ctrl_reg #(.NUM_GROUPS(2)) dut2 (
        .nvdla_core_clk (clk),     .nvdla_core_rst (rst),
        .reg_offset     (off[0]),  .reg_wr_data    (wdat[0]),
        .reg_wr_en      (wen[0]),  .reg_rd_data    (rd2),
        .producer       (prod2),   .consumer       (cons2),
        .op_en          (open2),   .op_start       (st[0]),
        .op_done        (dn[0]),   .done_irq       (irq2)
    );

    nvdla_cacc_group_ctrl_reg #(.NUM_GROUPS(4)) dut4 (
        .nvdla_core_clk (clk),     .nvdla_core_rst (rst),
        .reg_offset     (off[1]),  .reg_wr_data    (wdat[1]),
        .reg_wr_en      (wen[1]),  .reg_rd_data    (rd4),
        .producer       (prod4),   .consumer       (cons4),
        .op_en          (open4),   .op_start       (st[1]),
        .op_done        (dn[1]),   .done_irq       (irq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        off[sel] = a; wdat[sel] = d; wen[sel] = 1'b1;
        @(negedge clk);
        wen[sel] = 1'b0; wdat[sel] = '0;
    endtask

    task automatic rd_chk(input int sel, input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        off[sel] = a;
        #1;
        check(tag, (sel == 1) ? rd4 : rd2, exp);
    endtask

    task automatic pulse(input int sel, input logic s, input logic d, input logic exp_irq, input string tag);
        @(negedge clk);
        st[sel] = s; dn[sel] = d;
        @(negedge clk);
        st[sel] = 1'b0; dn[sel] = 1'b0;
        check({tag, "_irq"}, {31'b0, (sel == 1) ? irq4 : irq2}, {31'b0, exp_irq});
        @(negedge clk);
        check({tag, "_irq_end"}, {31'b0, (sel == 1) ? irq4 : irq2}, 32'h0);
    endtask

    // Hand-written status field positions for groups 0..3.
    int pos4 [4] = '{0, 16, 2, 18};

    initial begin
        logic [31:0] exp;
        for (int s = 0; s < 2; s++) begin
            off[s] = '0; wdat[s] = '0; wen[s] = 1'b0; st[s] = 1'b0; dn[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            rd_chk(s, A_STAT, 32'h0, "rst_status");
            rd_chk(s, A_PTR,  32'h0, "rst_pointer");
            rd_chk(s, A_OPEN, 32'h0, "rst_open");
            rd_chk(s, A_ERR,  32'h0, "rst_err");
        end
        check("rst_op_en", {28'b0, open4, open2}, 32'h0);
        check("rst_irq", {30'b0, irq4, irq2}, 32'h0);

        // Two-group basic flow
        wr(0, A_OPEN, 32'h1);
        rd_chk(0, A_STAT, 32'h0000_0002, "g2_pending");
        check("g2_op_en", {30'b0, open2}, 32'h1);
        rd_chk(0, A_OPEN, 32'h1, "g2_open_rd");
        pulse(0, 1'b1, 1'b0, 1'b0, "g2_start");
        rd_chk(0, A_STAT, 32'h0000_0001, "g2_running");
        pulse(0, 1'b0, 1'b1, 1'b1, "g2_done");
        rd_chk(0, A_STAT, 32'h0, "g2_idle");
        check("g2_cons", {31'b0, cons2}, 32'h1);
        rd_chk(0, A_PTR, 32'h0001_0000, "g2_pointer");
        rd_chk(0, A_ERR, 32'h0, "g2_err_clean");

        // Four groups, launch 3 first then 0..2, run all through consumer wrap
        wr(1, A_PTR, 32'h3);
        wr(1, A_OPEN, 32'h1);
        rd_chk(1, A_STAT, 32'h0008_0000, "g4_grp3_bits19_18");
        check("g4_op_en", {28'b0, open4}, 32'h8);
        for (int g = 0; g < 3; g++) begin
            wr(1, A_PTR, g);
            wr(1, A_OPEN, 32'h1);
        end
        rd_chk(1, A_STAT, 32'h000A_000A, "g4_all_pending");
        for (int i = 0; i < 4; i++) begin
            pulse(1, 1'b1, 1'b0, 1'b0, "g4_start");
            exp = '0;
            for (int g = 0; g < 4; g++) begin
                if (g == i)     exp[pos4[g] +: 2] = 2'd1;
                else if (g > i) exp[pos4[g] +: 2] = 2'd2;
            end
            rd_chk(1, A_STAT, exp, "g4_run_status");
            pulse(1, 1'b0, 1'b1, 1'b1, "g4_done");
            check("g4_cons", {30'b0, cons4}, (i + 1) % 4);
        end
        rd_chk(1, A_STAT, 32'h0, "g4_all_idle");
        rd_chk(1, A_PTR, 32'h0000_0002, "g4_pointer_wrapped");
        rd_chk(1, A_ERR, 32'h0, "g4_err_clean");

        // Double launch on group 0 of the 2-group block
        wr(0, A_OPEN, 32'h1);
        wr(0, A_OPEN, 32'h1);
        rd_chk(0, A_STAT, 32'h0000_0002, "dbl_still_pending");
        rd_chk(0, A_ERR, 32'h1, "dbl_err");
        wr(0, A_ERR, 32'h1);
        rd_chk(0, A_ERR, 32'h0, "dbl_err_cleared");

        // op_done while consumer group 1 is only PENDING
        wr(0, A_PTR, 32'h1);
        rd_chk(0, A_PTR, 32'h0001_0001, "ptr_rw");
        wr(0, A_OPEN, 32'h1);
        rd_chk(0, A_STAT, 32'h0002_0002, "two_pending");
        pulse(0, 1'b0, 1'b1, 1'b0, "early_done");
        rd_chk(0, A_STAT, 32'h0002_0002, "early_done_state");
        rd_chk(0, A_ERR, 32'h2, "early_done_err");
        check("early_done_cons", {31'b0, cons2}, 32'h1);
        wr(0, A_ERR, 32'h3);
        rd_chk(0, A_ERR, 32'h0, "err_cleared");

        // Start/done collision, then reset while a group runs
        pulse(0, 1'b1, 1'b0, 1'b0, "pre_start");
        rd_chk(0, A_STAT, 32'h0001_0002, "grp1_running");
        pulse(0, 1'b1, 1'b1, 1'b1, "collide");
        rd_chk(0, A_STAT, 32'h0000_0002, "collide_status");
        rd_chk(0, A_ERR, 32'h2, "collide_err");
        check("collide_cons", {31'b0, cons2}, 32'h0);
        pulse(0, 1'b1, 1'b0, 1'b0, "grp0_start");
        rd_chk(0, A_STAT, 32'h0000_0001, "grp0_running");

        @(negedge clk);
        rst = 1'b1;
        dn[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dn[0] = 1'b0;
        check("rst2_irq", {31'b0, irq2}, 32'h0);
        rd_chk(0, A_STAT, 32'h0, "rst2_status");
        rd_chk(0, A_PTR,  32'h0, "rst2_pointer");
        rd_chk(0, A_ERR,  32'h0, "rst2_err");
        check("rst2_op_en", {30'b0, open2}, 32'h0);
        check("rst2_irq_after", {31'b0, irq2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
